// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer: 2-bit counter states and PC width.
package branch_target_buffer_pkg;

  localparam int PC_W = 32;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_RST   = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup and training port bundle between the pipeline (master) and the BTB (slave).
interface branch_target_buffer_if;
  import branch_target_buffer_pkg::*;

  logic [PC_W-1:0] PC;
  logic            BTB_Hit;
  logic            Predict_Taken;
  logic [PC_W-1:0] BTB_Addr;
  logic            Update_En;
  logic [PC_W-1:0] Update_PC;
  logic            Update_Taken;
  logic [PC_W-1:0] Update_Target;

  modport master (
    output PC, Update_En, Update_PC, Update_Taken, Update_Target,
    input  BTB_Hit, Predict_Taken, BTB_Addr
  );

  modport slave (
    input  PC, Update_En, Update_PC, Update_Taken, Update_Target,
    output BTB_Hit, Predict_Taken, BTB_Addr
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating counter next-state: increments on taken, decrements on not-taken.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST)  ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup on PC, single training port from the resolve stage.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  branch_target_buffer_if.slave bus
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];
  ctr_t               ctr_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  ctr_t             ctr_nxt;

  // Byte offset bits never select an entry.
  logic unused_lo;
  assign unused_lo = ^{bus.PC[1:0], bus.Update_PC[1:0]};

  assign lk_idx = bus.PC[IDX_W+1:2];
  assign lk_tag = bus.PC[PC_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.BTB_Hit       = lk_hit;
  assign bus.Predict_Taken = lk_hit & ctr_q[lk_idx][1];
  assign bus.BTB_Addr      = lk_hit ? target_q[lk_idx] : '0;

  assign up_idx = bus.Update_PC[IDX_W+1:2];
  assign up_tag = bus.Update_PC[PC_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (bus.Update_Taken),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.Update_En) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_nxt;
        if (bus.Update_Taken) target_d[up_idx] = bus.Update_Target;
      end else if (bus.Update_Taken) begin
        // Not-taken misses are never allocated, so only taken misses replace.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bus.Update_Target;
        ctr_d[up_idx]    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target need no reset value; only hold them so a reset-cycle update is discarded.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scenarios plus a randomized lookup/update stream checked against a behavioural BTB model.
module tb_branch_target_buffer;

  logic CLK;
  logic RESET;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one record per index, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'(pc[5:2]);
    return m_valid[i] && (m_tag[i] == pc[31:6]);
  endfunction

  task automatic m_update();
    int i;
    if (RESET) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
    end else if (bus.Update_En) begin
      i = int'(bus.Update_PC[5:2]);
      if (m_hit(bus.Update_PC)) begin
        if (bus.Update_Taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = bus.Update_Target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bus.Update_Taken) begin
        m_valid[i] = 1;
        m_tag[i]   = bus.Update_PC[31:6];
        m_tgt[i]   = bus.Update_Target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic en,
                       input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    RESET             = rst;
    bus.PC            = pc;
    bus.Update_En     = en;
    bus.Update_PC     = upc;
    bus.Update_Taken  = tk;
    bus.Update_Target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_update();
    @(negedge CLK);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    drive(1'b0, 32'h0, 1'b1, upc, tk, tgt);
    tick();
  endtask

  task automatic chk_out(input string tag, input logic hit, input logic pred, input logic [31:0] addr);
    chk({tag, "_hit"},  {31'd0, bus.BTB_Hit},       {31'd0, hit});
    chk({tag, "_pred"}, {31'd0, bus.Predict_Taken}, {31'd0, pred});
    chk({tag, "_addr"}, bus.BTB_Addr,               addr);
  endtask

  initial begin
    logic [31:0] pc, upc, tgt;
    bit          exp_hit;
    int          ei;

    // T1 reset
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    look(32'h40);
    chk_out("t1", 1'b0, 1'b0, 32'h0);

    // T2 allocate
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40);
    chk_out("t2", 1'b1, 1'b1, 32'h100);
    look(32'h43);
    chk_out("t2_lowbits", 1'b1, 1'b1, 32'h100);

    // T3 hysteresis
    upd(32'h40, 1'b0, 32'hdead);
    look(32'h40);
    chk_out("t3_wnt", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40);
    chk_out("t3_wt", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    look(32'h40);
    chk_out("t3_st_dn", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look(32'h40);
    chk_out("t3_snt", 1'b1, 1'b0, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40);
    chk_out("t3_snt_up", 1'b1, 1'b0, 32'h100);

    // T4 no-allocate on not-taken, then alias eviction
    upd(32'h80, 1'b0, 32'h900);
    look(32'h80);
    chk_out("t4_noalloc", 1'b0, 1'b0, 32'h0);
    upd(32'h441, 1'b1, 32'h200);
    look(32'h40);
    chk_out("t4_evicted", 1'b0, 1'b0, 32'h0);
    look(32'h440);
    chk_out("t4_alias", 1'b1, 1'b1, 32'h200);

    // T5 same-cycle lookup/update: no bypass
    upd(32'h40, 1'b1, 32'h100);
    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300);
    chk_out("t5_old", 1'b1, 1'b1, 32'h100);
    tick();
    look(32'h40);
    chk_out("t5_new", 1'b1, 1'b1, 32'h300);

    // T6 reset discards a concurrent update
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500);
    tick();
    chk_out("t6_inrst", 1'b0, 1'b0, 32'h0);
    look(32'h40);
    chk_out("t6_after", 1'b0, 1'b0, 32'h0);
    look(32'h440);
    chk_out("t6_alias", 1'b0, 1'b0, 32'h0);

    // Random stream: small tag pool so hits, aliasing and saturation all occur.
    for (int c = 0; c < 1000; c++) begin
      pc  = {24'h0, $urandom_range(3, 0) << 6} | ($urandom_range(15, 0) << 2) | $urandom_range(3, 0);
      upc = {24'h0, $urandom_range(3, 0) << 6} | ($urandom_range(15, 0) << 2) | $urandom_range(3, 0);
      tgt = $urandom;
      if ($urandom_range(3, 0) == 0) upc = pc;
      drive($urandom_range(63, 0) == 0, pc, $urandom_range(3, 0) != 0, upc, $urandom_range(2, 0) != 0, tgt);
      exp_hit = m_hit(pc);
      ei      = int'(pc[5:2]);
      chk_out("rnd", exp_hit, exp_hit && (m_ctr[ei] >= 2), exp_hit ? m_tgt[ei] : 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
